// File: rtl/seq_stream_tester.sv
// Sequence generator and checker for exercising a FIFO: writes an incrementing stream and verifies it on the read side.
// Optional macro SEQ_STREAM_TESTER_HALT_EN freezes both sides in a HALT state after the first mismatch.
module seq_stream_tester #(
    parameter int Width      = 16,
    parameter int Step       = 1,
    parameter int GapCycles  = 0,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    output logic                  w_trigger,
    output logic [Width-1:0]      w_data,
    input  logic                  w_ok,
    output logic                  r_trigger,
    input  logic [Width-1:0]      r_data,
    input  logic                  r_ok,
    output logic [CountWidth-1:0] w_count,
    output logic [CountWidth-1:0] r_count,
    output logic [CountWidth-1:0] err_count,
    output logic [Width-1:0]      err_first_exp,
    output logic [Width-1:0]      err_first_got,
    output logic                  fail
);

    localparam int GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
    localparam logic [GapW-1:0] GAP_LOAD = (GapCycles > 0) ? GapW'(GapCycles - 1) : '0;
    localparam logic [Width-1:0] STEP_W = Width'(Step);
    localparam logic [CountWidth-1:0] CNT_MAX = {CountWidth{1'b1}};

`ifdef SEQ_STREAM_TESTER_HALT_EN
    typedef enum logic [1:0] {G_IDLE = 2'd0, G_RUN = 2'd1, G_GAP = 2'd2, G_HALT = 2'd3} gen_state_t;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_SYNC = 2'd1, C_CHECK = 2'd2, C_HALT = 2'd3} chk_state_t;
`else
    typedef enum logic [1:0] {G_IDLE = 2'd0, G_RUN = 2'd1, G_GAP = 2'd2} gen_state_t;
    typedef enum logic [1:0] {C_IDLE = 2'd0, C_SYNC = 2'd1, C_CHECK = 2'd2} chk_state_t;
`endif

    gen_state_t gen_state_reg, gen_state_next;
    chk_state_t chk_state_reg, chk_state_next;
    logic [GapW-1:0] gap_cnt_reg, gap_cnt_next;
    logic go_meta_reg, go_s_reg;
    logic w_trigger_reg, r_trigger_reg;
    logic [Width-1:0] w_data_reg, expected_reg, err_first_exp_reg, err_first_got_reg;
    logic [CountWidth-1:0] w_count_reg, r_count_reg, err_count_reg;
    logic fail_reg;

    logic w_xfer, r_xfer, mismatch;

    assign w_xfer   = w_trigger_reg && w_ok;
    assign r_xfer   = r_trigger_reg && r_ok;
    assign mismatch = r_xfer && (chk_state_reg == C_CHECK) && (r_data != expected_reg);

    always_comb begin
        gen_state_next = gen_state_reg;
        gap_cnt_next   = gap_cnt_reg;
        case (gen_state_reg)
            G_IDLE: if (go_s_reg) gen_state_next = G_RUN;
            G_RUN: begin
                if (w_xfer && (GapCycles > 0)) begin
                    gen_state_next = G_GAP;
                    gap_cnt_next   = GAP_LOAD;
                end
            end
            G_GAP: begin
                if (gap_cnt_reg == '0) gen_state_next = G_RUN;
                else                   gap_cnt_next   = gap_cnt_reg - GapW'(1);
            end
`ifdef SEQ_STREAM_TESTER_HALT_EN
            G_HALT: gen_state_next = G_HALT;
`endif
            default: gen_state_next = G_IDLE;
        endcase
`ifdef SEQ_STREAM_TESTER_HALT_EN
        if (mismatch) gen_state_next = G_HALT;
        else if (!go_s_reg && gen_state_reg != G_HALT) gen_state_next = G_IDLE;
`else
        if (!go_s_reg) gen_state_next = G_IDLE;
`endif
    end

    always_comb begin
        chk_state_next = chk_state_reg;
        case (chk_state_reg)
            C_IDLE:  if (go_s_reg) chk_state_next = C_SYNC;
            C_SYNC:  if (r_xfer) chk_state_next = C_CHECK;
            C_CHECK: chk_state_next = C_CHECK;
`ifdef SEQ_STREAM_TESTER_HALT_EN
            C_HALT:  chk_state_next = C_HALT;
`endif
            default: chk_state_next = C_IDLE;
        endcase
`ifdef SEQ_STREAM_TESTER_HALT_EN
        if (mismatch) chk_state_next = C_HALT;
        else if (!go_s_reg && chk_state_reg != C_HALT) chk_state_next = C_IDLE;
`else
        if (!go_s_reg) chk_state_next = C_IDLE;
`endif
    end

    // Triggers are registered copies of the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            go_meta_reg   <= 1'b0;
            go_s_reg      <= 1'b0;
            gen_state_reg <= G_IDLE;
            chk_state_reg <= C_IDLE;
            gap_cnt_reg   <= '0;
            w_trigger_reg <= 1'b0;
            r_trigger_reg <= 1'b0;
        end else begin
            go_meta_reg   <= go;
            go_s_reg      <= go_meta_reg;
            gen_state_reg <= gen_state_next;
            chk_state_reg <= chk_state_next;
            gap_cnt_reg   <= gap_cnt_next;
            w_trigger_reg <= (gen_state_next == G_RUN);
            r_trigger_reg <= (chk_state_next == C_SYNC) || (chk_state_next == C_CHECK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_data_reg        <= '0;
            expected_reg      <= '0;
            w_count_reg       <= '0;
            r_count_reg       <= '0;
            err_count_reg     <= '0;
            err_first_exp_reg <= '0;
            err_first_got_reg <= '0;
            fail_reg          <= 1'b0;
        end else begin
            if (w_xfer) begin
                w_data_reg <= w_data_reg + STEP_W;
                if (w_count_reg != CNT_MAX) w_count_reg <= w_count_reg + CountWidth'(1);
            end
            // Every read reloads the expectation, so a dropped word costs exactly one error.
            if (r_xfer) begin
                expected_reg <= r_data + STEP_W;
                if (r_count_reg != CNT_MAX) r_count_reg <= r_count_reg + CountWidth'(1);
            end
            if (mismatch) begin
                fail_reg <= 1'b1;
                if (err_count_reg != CNT_MAX) err_count_reg <= err_count_reg + CountWidth'(1);
                if (!fail_reg) begin
                    err_first_exp_reg <= expected_reg;
                    err_first_got_reg <= r_data;
                end
            end
        end
    end

    assign w_trigger     = w_trigger_reg;
    assign r_trigger     = r_trigger_reg;
    assign w_data        = w_data_reg;
    assign w_count       = w_count_reg;
    assign r_count       = r_count_reg;
    assign err_count     = err_count_reg;
    assign err_first_exp = err_first_exp_reg;
    assign err_first_got = err_first_got_reg;
    assign fail          = fail_reg;

endmodule

// File: tb/tb_seq_stream_tester.sv
// Bench: instance A loops back through a 4-deep FIFO model; instance B (Width=4, Step=3, GapCycles=2, CountWidth=4)
// covers wrap, gap pattern and counter saturation.
module tb_seq_stream_tester;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, go_a, go_b;

    logic        w_trigger_a, w_ok_a, r_trigger_a, r_ok_a, fail_a;
    logic [15:0] w_data_a, r_data_a, w_count_a, r_count_a, err_count_a, efe_a, efg_a;

    logic       w_trigger_b, w_ok_b, r_trigger_b, r_ok_b, fail_b;
    logic [3:0] w_data_b, r_data_b, w_count_b, r_count_b, err_count_b, efe_b, efg_b;

    seq_stream_tester #(.Width(16), .Step(1), .GapCycles(0), .CountWidth(16)) dut_a (
        .clk(clk), .rst(rst), .go(go_a),
        .w_trigger(w_trigger_a), .w_data(w_data_a), .w_ok(w_ok_a),
        .r_trigger(r_trigger_a), .r_data(r_data_a), .r_ok(r_ok_a),
        .w_count(w_count_a), .r_count(r_count_a), .err_count(err_count_a),
        .err_first_exp(efe_a), .err_first_got(efg_a), .fail(fail_a)
    );

    seq_stream_tester #(.Width(4), .Step(3), .GapCycles(2), .CountWidth(4)) dut_b (
        .clk(clk), .rst(rst), .go(go_b),
        .w_trigger(w_trigger_b), .w_data(w_data_b), .w_ok(w_ok_b),
        .r_trigger(r_trigger_b), .r_data(r_data_b), .r_ok(r_ok_b),
        .w_count(w_count_b), .r_count(r_count_b), .err_count(err_count_b),
        .err_first_exp(efe_b), .err_first_got(efg_b), .fail(fail_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are checked at the same point.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // 4-deep FIFO model between A's write and read ports, with optional loss of word 0x0005.
    logic [15:0] fifo_mem [4];
    int fifo_wr = 0, fifo_rd = 0, fifo_cnt = 0;
    logic wen_a, drop_en, push_a, pop_a;

    assign w_ok_a   = wen_a && (fifo_cnt < 4);
    assign r_ok_a   = r_trigger_a && (fifo_cnt > 0);
    assign r_data_a = fifo_mem[fifo_rd];
    assign push_a   = w_trigger_a && w_ok_a && !(drop_en && w_data_a == 16'h0005);
    assign pop_a    = r_ok_a;

    always @(posedge clk) begin
        if (rst) begin
            fifo_wr  <= 0;
            fifo_rd  <= 0;
            fifo_cnt <= 0;
        end else begin
            if (push_a) begin
                fifo_mem[fifo_wr] <= w_data_a;
                fifo_wr <= (fifo_wr + 1) % 4;
            end
            if (pop_a) fifo_rd <= (fifo_rd + 1) % 4;
            fifo_cnt <= fifo_cnt + (push_a ? 1 : 0) - (pop_a ? 1 : 0);
        end
    end

    // Scoreboard: the expected next write word is queued; each write transfer pops and compares it.
    logic [15:0] sb_q[$];
    int n_writes = 0;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            sb_q.push_back(16'h0000);
            n_writes <= 0;
        end else if (w_trigger_a && w_ok_a) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                check("w_data_a", {16'h0, w_data_a}, {16'h0, sb_q[0]});
                sb_q.push_back(sb_q[0] + 16'd1);
                void'(sb_q.pop_front());
            end
            n_writes <= n_writes + 1;
        end
    end

    typedef struct {
        logic       w_ok;
        logic       exp_trig;
        logic [3:0] exp_data;
    } vec_t;

    vec_t tbl[120];

    initial begin
        int k;
        for (int i = 0; i < 120; i++) begin
            tbl[i].w_ok     = 1'b1;
            tbl[i].exp_trig = (i % 3 == 0);
            tbl[i].exp_data = 4'((3 * ((i + 2) / 3)) % 16);
        end

        rst = 1'b1; go_a = 1'b0; go_b = 1'b0; wen_a = 1'b0; drop_en = 1'b0;
        w_ok_b = 1'b1; r_ok_b = 1'b0; r_data_b = 4'h0;
        repeat (3) tick();
        check("rst_w_trigger_a", w_trigger_a, 0);
        check("rst_r_trigger_a", r_trigger_a, 0);
        check("rst_w_data_a", w_data_a, 0);
        check("rst_counts_a", {w_count_a, r_count_a} | err_count_a, 0);
        check("rst_fail_a", fail_a, 0);
        check("rst_w_trigger_b", w_trigger_b, 0);

        // Ideal loopback for 1000 cycles.
        rst = 1'b0; go_a = 1'b1; wen_a = 1'b1;
        repeat (1000) tick();
        go_a = 1'b0;
        tick(); check("wtrig_fall_1", w_trigger_a, 1);
        tick(); check("wtrig_fall_2", w_trigger_a, 1);
        tick(); check("wtrig_fall_3", w_trigger_a, 0);
        check("rtrig_fall_3", r_trigger_a, 0);
        repeat (3) tick();
        check("ideal_err_count", err_count_a, 0);
        check("ideal_fail", fail_a, 0);
        check("ideal_w_count", w_count_a, 1000);
        check("ideal_r_count", r_count_a, 999);
        check("ideal_w_count_sb", w_count_a, n_writes);
        check("ideal_occupancy", r_count_a, n_writes - fifo_cnt);

        // Re-enable: checker resyncs, counters and w_data continue.
        go_a = 1'b1;
        repeat (60) tick();
        check("rego_err_count", err_count_a, 0);
        check("rego_fail", fail_a, 0);
        check("rego_w_count_grew", (w_count_a > 16'd1000), 1);

        // Reset mid-run, then the dropped-word run.
        rst = 1'b1; drop_en = 1'b1;
        tick();
        check("midrst_triggers", {w_trigger_a, r_trigger_a}, 0);
        check("midrst_w_data", w_data_a, 0);
        check("midrst_counts", {w_count_a, r_count_a} | err_count_a, 0);
        check("midrst_first", {efe_a, efg_a}, 0);
        check("midrst_fail", fail_a, 0);
        rst = 1'b0;
        tick(); check("rerun_trig_1", w_trigger_a, 0);
        tick(); check("rerun_trig_2", w_trigger_a, 0);
        tick(); check("rerun_trig_3", w_trigger_a, 1);
        repeat (200) tick();
        check("drop_err_count", err_count_a, 1);
        check("drop_first_exp", efe_a, 16'h0005);
        check("drop_first_got", efg_a, 16'h0006);
        check("drop_fail", fail_a, 1);
        check("drop_w_count_sb", w_count_a, n_writes);
`ifdef SEQ_STREAM_TESTER_HALT_EN
        check("drop_halt_w_trigger", w_trigger_a, 0);
        check("drop_halt_r_trigger", r_trigger_a, 0);
`else
        check("drop_run_w_trigger", w_trigger_a, 1);
`endif
        go_a = 1'b0;
        repeat (5) tick();

        // Instance B: gap pattern and 4-bit wrap with Step=3.
        go_b = 1'b1;
        k = 0;
        while (w_trigger_b !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        check("b_start_latency", k, 3);
        for (int i = 0; i < 120; i++) begin
            w_ok_b = tbl[i].w_ok;
            check($sformatf("b_trig[%0d]", i), w_trigger_b, tbl[i].exp_trig);
            check($sformatf("b_data[%0d]", i), w_data_b, tbl[i].exp_data);
            tick();
        end
        check("b_w_count_sat", w_count_b, 15);
        check("b_no_err_yet", err_count_b, 0);

        // Forced mismatches: constant zero read data.
        r_ok_b = 1'b1;
        repeat (25) tick();
        check("b_fail", fail_b, 1);
        check("b_first_exp", efe_b, 3);
        check("b_first_got", efg_b, 0);
`ifdef SEQ_STREAM_TESTER_HALT_EN
        check("b_halt_err_count", err_count_b, 1);
        check("b_halt_triggers", {w_trigger_b, r_trigger_b}, 0);
        go_b = 1'b0; repeat (4) tick(); go_b = 1'b1; repeat (6) tick();
        check("b_halt_stays", {w_trigger_b, r_trigger_b}, 0);
`else
        check("b_err_count_sat", err_count_b, 15);
        check("b_r_count_sat", r_count_b, 15);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_stream_tester.md
SEQ_STREAM_TESTER -- requirements
Module: seq_stream_tester

Interface
REQ-001 Parameter Width, default 16, data word width in bits (2..32).
REQ-002 Parameter Step, default 1, increment added to the data word after each transfer, taken modulo 2^Width.
REQ-003 Parameter GapCycles, default 0, number of idle cycles the generator inserts after each accepted write; 0 means back-to-back writes.
REQ-004 Parameter CountWidth, default 16, width of the transfer and error counters.
REQ-005 Port clk, input, 1: sole clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port go, input, 1: run enable, asynchronous to clk.
REQ-008 Port w_trigger, output, 1: write request to the FIFO under test.
REQ-009 Port w_data, output, Width: write data.
REQ-010 Port w_ok, input, 1: the FIFO accepts the write this cycle.
REQ-011 Port r_trigger, output, 1: read request to the FIFO under test.
REQ-012 Port r_data, input, Width: read data.
REQ-013 Port r_ok, input, 1: r_data is valid and consumed this cycle.
REQ-014 Port w_count, output, CountWidth: accepted writes, saturating.
REQ-015 Port r_count, output, CountWidth: checked reads, saturating.
REQ-016 Port err_count, output, CountWidth: mismatches, saturating.
REQ-017 Port err_first_exp, output, Width: expected value at the first mismatch.
REQ-018 Port err_first_got, output, Width: received value at the first mismatch.
REQ-019 Port fail, output, 1: sticky; high from the first mismatch until rst.

Function
REQ-020 go passes through a 2-flop synchronizer; go_s is the second flop, and go-to-go_s latency is 2 cycles.
REQ-021 A write transfer occurs on a cycle where w_trigger && w_ok; a read transfer occurs on a cycle where r_trigger && r_ok.
REQ-022 The generator FSM has states IDLE, RUN and GAP.
- IDLE to RUN when go_s=1.
- RUN to GAP on a write transfer when GapCycles>0.
- GAP to RUN after exactly GapCycles cycles.
- Any state to IDLE when go_s=0.
REQ-023 w_trigger is registered and is 1 only in RUN; it falls on the cycle after go_s falls.
REQ-024 On each write transfer, w_data <= w_data+Step (wrapping modulo 2^Width) and w_count increments; w_data is held otherwise, including across IDLE.
REQ-025 The checker FSM has states IDLE, SYNC and CHECK.
- IDLE to SYNC when go_s=1.
- SYNC to CHECK on the first read transfer.
- Any state to IDLE when go_s=0.
REQ-026 r_trigger is registered and is 1 in SYNC and CHECK.
REQ-027 SYNC read: expected <= r_data+Step; the read is not compared.
REQ-028 CHECK read: compare r_data with expected.
- Mismatch: err_count increments, fail <= 1, and if fail was 0 capture err_first_exp/err_first_got.
- Match or mismatch: expected <= r_data+Step, so the checker resynchronises and one dropped word counts as one error.
REQ-029 r_count increments on every read transfer, including the SYNC read.
REQ-030 All counters saturate at 2^CountWidth-1 and never wrap.
REQ-031 A write and a read transfer in the same cycle are independent and both take effect.
REQ-032 Re-assertion of go after deassertion re-enters SYNC; counters, fail and w_data are retained.

Reset
REQ-033 While rst=1 at a clk edge: both FSMs go to IDLE; w_trigger=0, r_trigger=0, w_data=0, all counters=0, err_first_*=0, fail=0, synchronizer flops=0.
REQ-034 Reset mid-transfer takes priority: a transfer coinciding with rst=1 is not counted.

Configuration
REQ-035 Macro SEQ_STREAM_TESTER_HALT_EN selects the behaviour after a mismatch.
- Defined: the first mismatch moves both FSMs to a terminal HALT state; triggers are 0 and remain 0 until rst, regardless of go.
- Undefined: there is no HALT state; the block keeps running and counting errors per REQ-028.

Verification
REQ-036 Ideal loopback (w to r through a 4-deep FIFO model), Width=16, go high for 1000 cycles -> err_count=0, fail=0, r_count=w_count-(FIFO occupancy).
REQ-037 FIFO model drops word 0x0005 -> err_count=1, err_first_exp=0x0005, err_first_got=0x0006, fail=1; later reads match again.
REQ-038 Width=4, Step=1, 40 writes -> w_data wraps 0xF to 0x0 with no error; Step=3 gives sequence 0,3,6,9,0xC,0xF,2,...
REQ-039 GapCycles=2, w_ok constantly 1 -> w_trigger pattern 1,0,0,1,0,0; w_count=N/3 over N cycles.
REQ-040 CountWidth=4 with 20 forced mismatches -> err_count stays at 15; with SEQ_STREAM_TESTER_HALT_EN defined, the first mismatch gives err_count=1 and triggers stay 0 until rst.
REQ-041 rst pulsed during a run -> all outputs read 0 on the next cycle; with go still high, w_trigger reasserts 3 cycles after rst falls.
